// File: rtl/life_ctrl_16x16.sv
// Controller for a 16x16 cellular-automaton array: streams a pattern in, steps
// generations (on demand or on a run timer) and streams the rows back out.
module life_ctrl_16x16 #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic [15:0]         load_data,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic                run,
    input  logic                single,
    input  logic [PERIOD_W-1:0] period,
    input  logic                dump_req,
    output logic [15:0]         out_row,
    output logic [3:0]          out_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         arr_vali,
    output logic [3:0]          arr_vali_sel,
    output logic                arr_write_enb,
    output logic                arr_step,
    output logic [3:0]          arr_valo_sel,
    input  logic [15:0]         arr_valo,
    output logic [15:0]         gen_count,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    // Stream handshakes: a beat transfers on the rising edge where valid and
    // ready are both high; the source holds its data stable until then.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_STEP = 2'd2,
        S_DUMP = 2'd3
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [3:0]          row_idx;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] period_m1;
    logic                timer_fire;
    logic                pending;
    logic                pend_run;
    logic                pending_n;
    logic                pend_run_n;

    assign period_m1  = (period == '0) ? '0 : period - 1'b1;
    assign timer_fire = run && (timer >= period_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        arr_step   = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (load_start) begin
                    next_state = S_LOAD;
                end else if (dump_req) begin
                    next_state = S_DUMP;
                end else if (pending) begin
                    next_state = S_STEP;
                end
            end
            // load_ready falls with the final write pulse; leave once it is low
            S_LOAD: begin
                if (!load_ready) begin
                    next_state = S_IDLE;
                end
            end
            S_STEP: begin
                arr_step   = 1'b1;
                next_state = S_IDLE;
            end
            S_DUMP: begin
                if (out_valid && out_ready && (row_idx == 4'hF)) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign state_dbg = state;

    // A single request survives run going low; a timer-sourced one does not.
    always_comb begin
        pending_n  = pending;
        pend_run_n = pend_run;
        if (state == S_STEP) begin
            pending_n  = 1'b0;
            pend_run_n = 1'b0;
        end
        if (!pending_n) begin
            if (single) begin
                pending_n  = 1'b1;
                pend_run_n = 1'b0;
            end else if (timer_fire) begin
                pending_n  = 1'b1;
                pend_run_n = 1'b1;
            end
        end
        if (!run && pend_run_n) begin
            pending_n  = 1'b0;
            pend_run_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer    <= '0;
            pending  <= 1'b0;
            pend_run <= 1'b0;
        end else begin
            pending  <= pending_n;
            pend_run <= pend_run_n;
            if (!run || timer_fire) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_idx       <= '0;
            load_ready    <= 1'b0;
            arr_write_enb <= 1'b0;
            arr_vali      <= '0;
            arr_vali_sel  <= '0;
            arr_valo_sel  <= '0;
            out_row       <= '0;
            out_idx       <= '0;
            out_valid     <= 1'b0;
            gen_count     <= '0;
        end else begin
            arr_write_enb <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (next_state == S_LOAD) begin
                        row_idx    <= '0;
                        load_ready <= 1'b1;
                    end else if (next_state == S_DUMP) begin
                        row_idx      <= '0;
                        arr_valo_sel <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_valid && load_ready) begin
                        arr_write_enb <= 1'b1;
                        arr_vali      <= load_data;
                        arr_vali_sel  <= row_idx;
                        row_idx       <= row_idx + 1'b1;
                        if (row_idx == 4'hF) begin
                            load_ready <= 1'b0;
                            gen_count  <= '0;
                        end
                    end
                end
                S_STEP: begin
                    gen_count <= gen_count + 1'b1;
                end
                S_DUMP: begin
                    // Capture in the cycle after the read select settles.
                    if (!out_valid) begin
                        out_row   <= arr_valo;
                        out_idx   <= row_idx;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid    <= 1'b0;
                        row_idx      <= row_idx + 1'b1;
                        arr_valo_sel <= row_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_ctrl_16x16.sv
// Bench for life_ctrl_16x16: a rotating-row array stub, randomized load/dump
// traffic checked against a row/generation reference model.
module tb_life_ctrl_16x16;
    localparam int PW = 24;

    logic          clk;
    logic          reset;
    logic          load_start;
    logic [15:0]   load_data;
    logic          load_valid;
    logic          load_ready;
    logic          run;
    logic          single;
    logic [PW-1:0] period;
    logic          dump_req;
    logic [15:0]   out_row;
    logic [3:0]    out_idx;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   arr_vali;
    logic [3:0]    arr_vali_sel;
    logic          arr_write_enb;
    logic          arr_step;
    logic [3:0]    arr_valo_sel;
    logic [15:0]   arr_valo;
    logic [15:0]   gen_count;
    logic          busy;
    logic [1:0]    state_dbg;

    life_ctrl_16x16 #(.PERIOD_W(PW)) dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_data(load_data),
        .load_valid(load_valid), .load_ready(load_ready),
        .run(run), .single(single), .period(period), .dump_req(dump_req),
        .out_row(out_row), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .arr_vali(arr_vali), .arr_vali_sel(arr_vali_sel),
        .arr_write_enb(arr_write_enb), .arr_step(arr_step),
        .arr_valo_sel(arr_valo_sel), .arr_valo(arr_valo),
        .gen_count(gen_count), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // array stub: each generation rotates every row left by one
    logic [15:0] mem [16];
    assign arr_valo = mem[arr_valo_sel];
    always @(posedge clk) begin
        if (arr_write_enb) begin
            mem[arr_vali_sel] <= arr_vali;
        end else if (arr_step) begin
            for (int i = 0; i < 16; i++) mem[i] <= {mem[i][14:0], mem[i][15]};
        end
    end

    // scoreboard
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [19:0] exp_q[$];
    logic [19:0] w_exp;
    logic [15:0] pat [16];
    logic [15:0] pat_model [16];
    int n_writes = 0;
    int n_steps = 0;
    int steps_at_load = 0;
    int last_step_cyc = 0;
    bit have_prev = 0;
    bit gap_en = 0;
    int exp_gap = 0;
    int exp_gen = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (arr_write_enb || arr_step) check("wr_step_excl", 32'(arr_write_enb & arr_step), 0);
            if (arr_write_enb) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("write_unexpected", 1, 0);
                end else begin
                    w_exp = exp_q.pop_front();
                    check("write_sel", 32'(arr_vali_sel), 32'(w_exp[19:16]));
                    check("write_data", 32'(arr_vali), 32'(w_exp[15:0]));
                end
            end
            if (arr_step) begin
                n_steps++;
                if (gap_en && have_prev) check("step_gap", cyc - last_step_cyc, exp_gap);
                have_prev = 1;
                last_step_cyc = cyc;
            end
        end
    end

    function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
        int s;
        s = n % 16;
        if (s == 0) return x;
        return (x << s) | (x >> (16 - s));
    endfunction

    // driver tasks
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input bit stuck, input int rows, input bit pulse_start);
        int k;
        int guard;
        bit hs;
        if (pulse_start) begin
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
        end
        k = 0;
        guard = 0;
        load_data = pat[0];
        load_valid = stuck ? 1'b1 : 1'($urandom_range(0, 1));
        while (k < rows && guard < 200) begin
            @(negedge clk);
            hs = load_valid && load_ready;
            if (hs) exp_q.push_back({k[3:0], load_data});
            @(posedge clk);
            #1;
            guard++;
            if (hs) k++;
            load_data = pat[k % 16];
            load_valid = stuck ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        load_valid = 1'b0;
        if (guard >= 200) check("load_timeout", 1, 0);
        for (int i = 0; i < 16; i++) pat_model[i] = pat[i];
        steps_at_load = n_steps;
        exp_gen = 0;
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (busy && g < 100);
        if (busy) check(tag, 1, 0);
    endtask

    task automatic do_dump(input int stall);
        int g;
        int st;
        logic [15:0] e;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int r = 0; r < 16; r++) begin
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!out_valid && g < 20);
            if (!out_valid) check("dump_timeout", 0, 1);
            e = rotl(pat_model[r], n_steps - steps_at_load);
            check("dump_idx", 32'(out_idx), r);
            check("dump_row", 32'(out_row), 32'(e));
            st = (stall < 0) ? $urandom_range(0, 3) : stall;
            repeat (st) begin
                @(negedge clk);
                check("dump_hold_valid", 32'(out_valid), 1);
                check("dump_hold_idx", 32'(out_idx), r);
                check("dump_hold_row", 32'(out_row), 32'(e));
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            check("dump_valid_drop", 32'(out_valid), 0);
        end
        wait_idle("dump_exit_timeout");
    endtask

    task automatic pulse_single();
        single = 1'b1;
        tick();
        single = 1'b0;
    endtask

    int s0;
    int w0;
    int cnt;

    initial begin
        reset = 1'b1;
        load_start = 0; load_data = 0; load_valid = 0; run = 0; single = 0;
        period = 0; dump_req = 0; out_ready = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        tick(3);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_load_ready", 32'(load_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_gen_count", 32'(gen_count), 0);
        check("rst_wr_step", 32'({arr_write_enb, arr_step}), 0);
        check("rst_out_row_idx", 32'({out_row, out_idx}), 0);
        check("rst_arr_sel", 32'({arr_vali, arr_vali_sel, arr_valo_sel}), 0);
        reset = 1'b0;
        tick(2);

        // walking-one load, load_valid stuck high, then backpressured dump
        for (int i = 0; i < 16; i++) pat[i] = 16'h0001 << i;
        w0 = n_writes;
        do_load(1, 16, 1);
        wait_idle("load_exit_timeout");
        check("load_writes", n_writes - w0, 16);
        check("load_exp_q_empty", exp_q.size(), 0);
        check("load_gen_count", 32'(gen_count), 0);
        check("load_busy_drop", 32'(busy), 0);
        do_dump(5);

        // random pattern with gappy load, random single steps, random stalls
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 16; i++) pat[i] = 16'($urandom);
            do_load(0, 16, 1);
            wait_idle("rload_exit_timeout");
            cnt = $urandom_range(1, 4);
            for (int j = 0; j < cnt; j++) begin
                pulse_single();
                tick($urandom_range(2, 4));
                exp_gen++;
            end
            check("single_gen_count", 32'(gen_count), exp_gen);
            check("single_steps", n_steps - steps_at_load, exp_gen);
            do_dump(-1);
        end

        // run rate, period 4
        period = 4;
        gap_en = 1; have_prev = 0; exp_gap = 4;
        s0 = n_steps;
        run = 1'b1;
        tick(40);
        run = 1'b0;
        tick(5);
        gap_en = 0;
        cnt = n_steps - s0;
        check("run4_count_in_range", 32'(cnt >= 9 && cnt <= 11), 1);
        exp_gen += cnt;
        check("run4_gen_count", 32'(gen_count), exp_gen);
        tick(6);
        check("run_off_no_steps", n_steps - s0, cnt);

        // period 0 behaves as 1: STEP and IDLE alternate
        period = 0;
        gap_en = 1; have_prev = 0; exp_gap = 2;
        s0 = n_steps;
        run = 1'b1;
        tick(20);
        run = 1'b0;
        tick(4);
        gap_en = 0;
        cnt = n_steps - s0;
        check("run0_count_in_range", 32'(cnt >= 9 && cnt <= 11), 1);
        exp_gen += cnt;
        check("run0_gen_count", 32'(gen_count), exp_gen);

        // single during LOAD produces exactly one step after LOAD
        for (int i = 0; i < 16; i++) pat[i] = 16'($urandom);
        s0 = n_steps;
        fork
            do_load(1, 16, 1);
            begin
                tick(6);
                pulse_single();
            end
        join
        tick(10);
        check("load_single_steps", n_steps - s0, 1);
        check("load_single_gen", 32'(gen_count), 1);

        // load_start and dump_req together: LOAD wins
        for (int i = 0; i < 16; i++) pat[i] = 16'($urandom);
        load_start = 1'b1;
        dump_req = 1'b1;
        tick();
        load_start = 1'b0;
        dump_req = 1'b0;
        @(negedge clk);
        check("conflict_load_ready", 32'(load_ready), 1);
        check("conflict_no_dump", 32'(out_valid), 0);
        tick();
        do_load(0, 16, 0);
        wait_idle("conflict_exit_timeout");
        check("conflict_gen", 32'(gen_count), 0);
        do_dump(-1);

        // gen_count wrap at 0xFFFF
        force dut.gen_count = 16'hFFFF;
        tick();
        release dut.gen_count;
        tick();
        pulse_single();
        tick(4);
        check("gen_wrap", 32'(gen_count), 0);

        // reset during LOAD after row 7
        for (int i = 0; i < 16; i++) pat[i] = 16'($urandom);
        do_load(1, 8, 1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        w0 = n_writes;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_load_ready", 32'(load_ready), 0);
        check("mid_rst_wr_enb", 32'(arr_write_enb), 0);
        check("mid_rst_vali", 32'({arr_vali, arr_vali_sel}), 0);
        check("mid_rst_gen", 32'(gen_count), 0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        load_valid = 1'b1;
        load_data = 16'hBEEF;
        tick(10);
        load_valid = 1'b0;
        check("mid_rst_no_writes", n_writes - w0, 0);
        check("mid_rst_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
